ace_snoop_responder: RTL and testbench

- Cache-side responder for the ACE snoop channels (AC request in, CR response out, CD data out).
- Sits between the interconnect snoop arbiter and the L1 tag/data arrays of one CPU.
- For each snoop it looks up the line, downgrades or invalidates it, returns CRRESP and, on a hit, serializes the full line onto CD.
- It is the counterpart of the interconnect's snoop initiator.

---
 rtl/ace_snoop_responder_pkg.sv | 56 +++++
 rtl/ace_snoop_responder_cd_beat_serializer.sv | 62 ++++++
 rtl/ace_snoop_responder.sv | 185 ++++++++++++++++++
 tb/tb_ace_snoop_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ace_snoop_responder_pkg.sv
// ----------------------------------------------------------------------------
// ace_snoop_responder_pkg
// Shared types and constants for the ACE snoop responder:
//   - snoop_resp_state_t : responder FSM states
//   - ACSNOOP codes handled by this cache (ReadClean, ReadUnique)
//   - CRRESP bit positions {WasUnique,IsShared,PassDirty,Error,DataTransfer}
//   - line geometry (BYTES_PER_LINE, CD_LEN beats per line)
//   - calc_crresp / snoop_supported helpers used by the responder
// ----------------------------------------------------------------------------
package ace_snoop_responder_pkg;

   localparam int BYTES_PER_LINE = 32;
   localparam int CD_LEN         = 8;

   typedef enum logic [2:0] {
      IDLE_S,
      LOOKUP_S,
      WAIT_RSP_S,
      UPDATE_S,
      SEND_CR_S,
      SEND_CD_S
   } snoop_resp_state_t;

   localparam logic [3:0] ACSNOOP_READ_CLEAN  = 4'b0010;
   localparam logic [3:0] ACSNOOP_READ_UNIQUE = 4'b0111;

   localparam int CR_DT  = 0;
   localparam int CR_ERR = 1;
   localparam int CR_PD  = 2;
   localparam int CR_IS  = 3;
   localparam int CR_WU  = 4;

   function automatic logic snoop_supported(input logic [3:0] snoop);
      return (snoop == ACSNOOP_READ_CLEAN) || (snoop == ACSNOOP_READ_UNIQUE);
   endfunction

   // Unsupported codes answer Error only; a miss answers all zeros.
   // ReadClean leaves a shared copy behind, ReadUnique leaves none.
   function automatic logic [4:0] calc_crresp(input logic [3:0] snoop,
                                              input logic       hit,
                                              input logic       dirty,
                                              input logic       is_unique);
      logic [4:0] r;
      r = '0;
      if (!snoop_supported(snoop)) begin
         r[CR_ERR] = 1'b1;
      end else if (hit) begin
         r[CR_DT] = 1'b1;
         r[CR_PD] = dirty;
         r[CR_IS] = (snoop == ACSNOOP_READ_CLEAN);
         r[CR_WU] = is_unique;
      end
      return r;
   endfunction

endpackage

// File: rtl/ace_snoop_responder_cd_beat_serializer.sv
// ----------------------------------------------------------------------------
// cd_beat_serializer
// Streams one cache line onto the CD channel, lowest word first.
//   clk, rst  : clock, synchronous active-high reset (aborts any burst)
//   load      : start a burst from beat 0 of 'line'
//   line      : line data; must stay stable for the whole burst
//   cd_valid/cd_ready/cd_data/cd_last : CD beat handshake (registered)
//   done      : high in the cycle of the final beat handshake
// Handshake: a beat transfers on a rising edge where cd_valid && cd_ready;
// cd_valid, cd_data and cd_last hold steady while cd_ready is low.
// ----------------------------------------------------------------------------
module cd_beat_serializer #(
   parameter int CD_DATA_WIDTH = 32,
   parameter int LINE_WIDTH    = 256
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic [LINE_WIDTH-1:0]    line,
   output logic                     cd_valid,
   input  logic                     cd_ready,
   output logic [CD_DATA_WIDTH-1:0] cd_data,
   output logic                     cd_last,
   output logic                     done
);

   localparam int CD_BEATS = LINE_WIDTH / CD_DATA_WIDTH;
   localparam int BEAT_W   = (CD_BEATS > 1) ? $clog2(CD_BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CD_BEATS - 1);

   logic [BEAT_W-1:0] beat;
   logic [BEAT_W-1:0] beat_nxt;

   assign beat_nxt = beat + 1'b1;
   assign done     = cd_valid && cd_ready && cd_last;

   always_ff @(posedge clk) begin
      if (rst) begin
         cd_valid <= 1'b0;
         cd_data  <= '0;
         cd_last  <= 1'b0;
         beat     <= '0;
      end else if (load) begin
         cd_valid <= 1'b1;
         cd_data  <= line[CD_DATA_WIDTH-1:0];
         cd_last  <= (CD_BEATS == 1);
         beat     <= '0;
      end else if (cd_valid && cd_ready) begin
         if (cd_last) begin
            cd_valid <= 1'b0;
            cd_data  <= '0;
            cd_last  <= 1'b0;
            beat     <= '0;
         end else begin
            beat     <= beat_nxt;
            cd_data  <= line[CD_DATA_WIDTH*beat_nxt +: CD_DATA_WIDTH];
            cd_last  <= (beat_nxt == LAST_BEAT);
         end
      end
   end

endmodule

// File: rtl/ace_snoop_responder.sv
// ----------------------------------------------------------------------------
// ace_snoop_responder
// Cache-side ACE snoop responder for one CPU's L1. For each AC snoop it looks
// the line up, downgrades or invalidates it, answers on CR and, on a hit,
// sends the whole line on CD. One snoop is outstanding at a time.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   ac_valid/ac_ready/ac_addr/ac_snoop/ac_prot : snoop request (prot unused)
//   cr_valid/cr_ready/cr_resp     : snoop response
//   cd_valid/cd_ready/cd_data/cd_last : snoop data beats
//   lk_valid/lk_ready/lk_addr     : tag/data lookup request (line aligned)
//   lk_rsp_valid/lk_hit/lk_dirty/lk_unique/lk_line : lookup result
//   upd_valid/upd_ready/upd_op    : line state update (0 downgrade, 1 inval)
// Optional: define SNOOP_PERF_CNT_EN to add 32-bit snoop_hit_cnt and
// snoop_miss_cnt outputs counting supported snoops by lookup outcome.
// Handshakes: every valid/ready pair transfers on a rising edge where both
// are high; a source holds valid and payload steady until that edge.
// ----------------------------------------------------------------------------
module ace_snoop_responder
   import ace_snoop_responder_pkg::*;
#(
   parameter int ADDR_WIDTH    = 32,
   parameter int CD_DATA_WIDTH = 32,
   parameter int LINE_WIDTH    = BYTES_PER_LINE * 8,
   parameter int CRRESP_WIDTH  = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ac_valid,
   output logic                     ac_ready,
   input  logic [ADDR_WIDTH-1:0]    ac_addr,
   input  logic [3:0]               ac_snoop,
   input  logic [2:0]               ac_prot,
   output logic                     cr_valid,
   input  logic                     cr_ready,
   output logic [CRRESP_WIDTH-1:0]  cr_resp,
   output logic                     cd_valid,
   input  logic                     cd_ready,
   output logic [CD_DATA_WIDTH-1:0] cd_data,
   output logic                     cd_last,
   output logic                     lk_valid,
   input  logic                     lk_ready,
   output logic [ADDR_WIDTH-1:0]    lk_addr,
   input  logic                     lk_rsp_valid,
   input  logic                     lk_hit,
   input  logic                     lk_dirty,
   input  logic                     lk_unique,
   input  logic [LINE_WIDTH-1:0]    lk_line,
   output logic                     upd_valid,
   input  logic                     upd_ready,
`ifdef SNOOP_PERF_CNT_EN
   output logic                     upd_op,
   output logic [31:0]              snoop_hit_cnt,
   output logic [31:0]              snoop_miss_cnt
`else
   output logic                     upd_op
`endif
);

   localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);

   snoop_resp_state_t     state;
   logic [3:0]            snoop_q;
   logic [LINE_WIDTH-1:0] line_q;
   logic [4:0]            resp_calc;
   logic                  upd_needed;
   logic                  ser_load;
   logic                  ser_done;
   logic                  in_unused;

   // Protection and the byte offset inside the line play no part in a snoop.
   assign in_unused = ^{ac_prot, ac_addr[OFF_BITS-1:0]};

   assign resp_calc  = calc_crresp(snoop_q, lk_hit, lk_dirty, lk_unique);
   assign upd_needed = snoop_supported(snoop_q) && lk_hit;

   // The data burst starts on the CR handshake that carries DataTransfer.
   assign ser_load = (state == SEND_CR_S) && cr_valid && cr_ready && cr_resp[CR_DT];

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE_S;
         ac_ready  <= 1'b1;
         cr_valid  <= 1'b0;
         cr_resp   <= '0;
         lk_valid  <= 1'b0;
         lk_addr   <= '0;
         upd_valid <= 1'b0;
         upd_op    <= 1'b0;
         snoop_q   <= '0;
         line_q    <= '0;
      end else begin
         case (state)
            IDLE_S: begin
               if (ac_valid && ac_ready) begin
                  ac_ready <= 1'b0;
                  snoop_q  <= ac_snoop;
                  lk_addr  <= {ac_addr[ADDR_WIDTH-1:OFF_BITS], OFF_BITS'(0)};
                  lk_valid <= 1'b1;
                  state    <= LOOKUP_S;
               end
            end
            LOOKUP_S: begin
               if (lk_ready) begin
                  lk_valid <= 1'b0;
                  state    <= WAIT_RSP_S;
               end
            end
            WAIT_RSP_S: begin
               if (lk_rsp_valid) begin
                  line_q  <= lk_line;
                  cr_resp <= CRRESP_WIDTH'(resp_calc);
                  if (upd_needed) begin
                     upd_valid <= 1'b1;
                     upd_op    <= (snoop_q == ACSNOOP_READ_UNIQUE);
                     state     <= UPDATE_S;
                  end else begin
                     cr_valid <= 1'b1;
                     state    <= SEND_CR_S;
                  end
               end
            end
            UPDATE_S: begin
               if (upd_ready) begin
                  upd_valid <= 1'b0;
                  cr_valid  <= 1'b1;
                  state     <= SEND_CR_S;
               end
            end
            SEND_CR_S: begin
               if (cr_ready) begin
                  cr_valid <= 1'b0;
                  if (cr_resp[CR_DT]) begin
                     state <= SEND_CD_S;
                  end else begin
                     ac_ready <= 1'b1;
                     state    <= IDLE_S;
                  end
               end
            end
            SEND_CD_S: begin
               if (ser_done) begin
                  ac_ready <= 1'b1;
                  state    <= IDLE_S;
               end
            end
            default: begin
               state <= IDLE_S;
            end
         endcase
      end
   end

`ifdef SNOOP_PERF_CNT_EN
   // Counted at the lookup result; unsupported codes are not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         snoop_hit_cnt  <= '0;
         snoop_miss_cnt <= '0;
      end else if ((state == WAIT_RSP_S) && lk_rsp_valid && snoop_supported(snoop_q)) begin
         if (lk_hit) begin
            snoop_hit_cnt <= snoop_hit_cnt + 32'd1;
         end else begin
            snoop_miss_cnt <= snoop_miss_cnt + 32'd1;
         end
      end
   end
`endif

   cd_beat_serializer #(
      .CD_DATA_WIDTH (CD_DATA_WIDTH),
      .LINE_WIDTH    (LINE_WIDTH)
   ) u_cd_ser (
      .clk      (clk),
      .rst      (rst),
      .load     (ser_load),
      .line     (line_q),
      .cd_valid (cd_valid),
      .cd_ready (cd_ready),
      .cd_data  (cd_data),
      .cd_last  (cd_last),
      .done     (ser_done)
   );

endmodule

// File: tb/tb_ace_snoop_responder.sv
// ----------------------------------------------------------------------------
// tb_ace_snoop_responder
// Directed bench for ace_snoop_responder: drives AC snoops, plays the cache
// lookup/update side and the CR/CD sinks, and checks every response against
// hand-computed values. Expected CD beats are queued in exp_q.
// ----------------------------------------------------------------------------
module tb_ace_snoop_responder;

   logic         clk;
   logic         rst;
   logic         ac_valid;
   logic         ac_ready;
   logic [31:0]  ac_addr;
   logic [3:0]   ac_snoop;
   logic [2:0]   ac_prot;
   logic         cr_valid;
   logic         cr_ready;
   logic [4:0]   cr_resp;
   logic         cd_valid;
   logic         cd_ready;
   logic [31:0]  cd_data;
   logic         cd_last;
   logic         lk_valid;
   logic         lk_ready;
   logic [31:0]  lk_addr;
   logic         lk_rsp_valid;
   logic         lk_hit;
   logic         lk_dirty;
   logic         lk_unique;
   logic [255:0] lk_line;
   logic         upd_valid;
   logic         upd_ready;
   logic         upd_op;
`ifdef SNOOP_PERF_CNT_EN
   logic [31:0]  snoop_hit_cnt;
   logic [31:0]  snoop_miss_cnt;
`endif

   int vectors     = 0;
   int miscompares = 0;
   logic [31:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   ace_snoop_responder dut (
      .clk          (clk),
      .rst          (rst),
      .ac_valid     (ac_valid),
      .ac_ready     (ac_ready),
      .ac_addr      (ac_addr),
      .ac_snoop     (ac_snoop),
      .ac_prot      (ac_prot),
      .cr_valid     (cr_valid),
      .cr_ready     (cr_ready),
      .cr_resp      (cr_resp),
      .cd_valid     (cd_valid),
      .cd_ready     (cd_ready),
      .cd_data      (cd_data),
      .cd_last      (cd_last),
      .lk_valid     (lk_valid),
      .lk_ready     (lk_ready),
      .lk_addr      (lk_addr),
      .lk_rsp_valid (lk_rsp_valid),
      .lk_hit       (lk_hit),
      .lk_dirty     (lk_dirty),
      .lk_unique    (lk_unique),
      .lk_line      (lk_line),
      .upd_valid    (upd_valid),
      .upd_ready    (upd_ready),
`ifdef SNOOP_PERF_CNT_EN
      .upd_op       (upd_op),
      .snoop_hit_cnt  (snoop_hit_cnt),
      .snoop_miss_cnt (snoop_miss_cnt)
`else
      .upd_op       (upd_op)
`endif
   );

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- drivers ----------------
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return lk_valid;
         1:       return cr_valid;
         default: return cd_valid;
      endcase
   endfunction

   // Waits (bounded) for the selected output to go high; returns cycles waited.
   task automatic wait_sig(input int which, input string tag, output int n);
      n = 0;
      while (sig(which) !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      if (n == 20) check({tag, " timeout"}, 32'd0, 32'd1);
   endtask

   function automatic logic [255:0] make_line(input logic [31:0] base);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[32*k +: 32] = base + 32'(k);
      return l;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, " ac_ready"},  32'(ac_ready),  32'd1);
      check({tag, " cr_valid"},  32'(cr_valid),  32'd0);
      check({tag, " cr_resp"},   32'(cr_resp),   32'd0);
      check({tag, " cd_valid"},  32'(cd_valid),  32'd0);
      check({tag, " cd_data"},   cd_data,        32'd0);
      check({tag, " cd_last"},   32'(cd_last),   32'd0);
      check({tag, " lk_valid"},  32'(lk_valid),  32'd0);
      check({tag, " lk_addr"},   lk_addr,        32'd0);
      check({tag, " upd_valid"}, 32'(upd_valid), 32'd0);
      check({tag, " upd_op"},    32'(upd_op),    32'd0);
   endtask

   // One complete snoop. stall_beat/abort_beat < 0 disable those features;
   // exp_lat < 0 skips the accept-to-cr_valid latency check.
   task automatic run_snoop(input logic [31:0] addr, input logic [3:0] snoop,
                            input logic hit, input logic dirty, input logic uniq,
                            input logic [255:0] line, input logic [4:0] exp_resp,
                            input logic exp_upd, input logic exp_op,
                            input int stall_beat, input int stall_len,
                            input int abort_beat, input int exp_lat);
      int lat;
      int n;
      logic [31:0] w;
      check("ac_ready idle", 32'(ac_ready), 32'd1);
      ac_valid = 1'b1;
      ac_addr  = addr;
      ac_snoop = snoop;
      ac_prot  = 3'($urandom_range(0, 7));
      tick();
      ac_valid = 1'b0;
      lat = 1;
      check("ac_ready busy", 32'(ac_ready), 32'd0);
      wait_sig(0, "lk_valid", n);
      lat += n;
      check("lk_addr", lk_addr, {addr[31:5], 5'b0});
      lk_ready = 1'b1;
      tick();
      lk_ready = 1'b0;
      lat++;
      check("lk_valid drop", 32'(lk_valid), 32'd0);
      lk_rsp_valid = 1'b1;
      lk_hit       = hit;
      lk_dirty     = dirty;
      lk_unique    = uniq;
      lk_line      = line;
      tick();
      lk_rsp_valid = 1'b0;
      lat++;
      if (exp_upd) begin
         check("upd_valid", 32'(upd_valid), 32'd1);
         check("upd_op", 32'(upd_op), 32'(exp_op));
         check("cr before upd", 32'(cr_valid), 32'd0);
         upd_ready = 1'b1;
         tick();
         upd_ready = 1'b0;
         check("upd_valid drop", 32'(upd_valid), 32'd0);
      end else begin
         check("no upd", 32'(upd_valid), 32'd0);
      end
      wait_sig(1, "cr_valid", n);
      lat += n;
      if (exp_lat >= 0) check("miss latency", 32'(lat), 32'(exp_lat));
      check("cr_resp", 32'(cr_resp), 32'(exp_resp));
      cr_ready = 1'b1;
      tick();
      cr_ready = 1'b0;
      check("cr_valid drop", 32'(cr_valid), 32'd0);
      if (!exp_resp[0]) begin
         check("no cd", 32'(cd_valid), 32'd0);
         check("ac_ready after cr", 32'(ac_ready), 32'd1);
         return;
      end
      for (int k = 0; k < 8; k++) exp_q.push_back(line[32*k +: 32]);
      for (int k = 0; k < 8; k++) begin
         wait_sig(2, "cd_valid", n);
         w = exp_q.pop_front();
         check("cd_data", cd_data, w);
         check("cd_last", 32'(cd_last), 32'(k == 7));
         if (k == abort_beat) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check_reset_outputs("abort");
            exp_q.delete();
            repeat (3) begin
               tick();
               check("abort no cd", 32'(cd_valid), 32'd0);
               check("abort no last", 32'(cd_last), 32'd0);
            end
            return;
         end
         if (k == stall_beat) begin
            repeat (stall_len) begin
               tick();
               check("stall valid", 32'(cd_valid), 32'd1);
               check("stall data", cd_data, w);
            end
         end
         cd_ready = 1'b1;
         tick();
         cd_ready = 1'b0;
      end
      check("ac_ready after cd", 32'(ac_ready), 32'd1);
      check("cd_valid drop", 32'(cd_valid), 32'd0);
      check("beats left", 32'(exp_q.size()), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst          = 1'b1;
      ac_valid     = 1'b0;
      ac_addr      = '0;
      ac_snoop     = '0;
      ac_prot      = '0;
      cr_ready     = 1'b0;
      cd_ready     = 1'b0;
      lk_ready     = 1'b0;
      lk_rsp_valid = 1'b0;
      lk_hit       = 1'b0;
      lk_dirty     = 1'b0;
      lk_unique    = 1'b0;
      lk_line      = '0;
      upd_ready    = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      rst = 1'b0;
      tick();

      // ReadClean miss: all-zero response, minimum latency 3
      run_snoop(32'h0000_1040, 4'b0010, 1'b0, 1'b0, 1'b0, make_line(32'h0),
                5'b00000, 1'b0, 1'b0, -1, 0, -1, 3);
      // ReadClean hit dirty unique, unaligned address
      run_snoop(32'h0000_1044, 4'b0010, 1'b1, 1'b1, 1'b1, make_line(32'hA0),
                5'b11101, 1'b1, 1'b0, -1, 0, -1, -1);
      // ReadUnique hit clean shared
      run_snoop(32'h0000_2000, 4'b0111, 1'b1, 1'b0, 1'b0, make_line(32'hB0),
                5'b00001, 1'b1, 1'b1, -1, 0, -1, -1);
      // ReadUnique hit dirty, CD stalled 3 cycles on beat 2
      run_snoop(32'h0000_30FF, 4'b0111, 1'b1, 1'b1, 1'b0, make_line(32'hC0DE_0000),
                5'b00101, 1'b1, 1'b1, 2, 3, -1, -1);
      // Unsupported code on a hit: Error only
      run_snoop(32'h0000_4000, 4'b1101, 1'b1, 1'b1, 1'b1, make_line(32'hD0),
                5'b00010, 1'b0, 1'b0, -1, 0, -1, -1);
      // ReadClean hit, reset during beat 4
      run_snoop(32'h0000_5020, 4'b0010, 1'b1, 1'b0, 1'b1, make_line(32'hE0),
                5'b11001, 1'b1, 1'b0, -1, 0, 4, -1);
      // Miss after the aborted burst completes normally
      run_snoop(32'h0000_6000, 4'b0010, 1'b0, 1'b0, 1'b0, make_line(32'h0),
                5'b00000, 1'b0, 1'b0, -1, 0, -1, 3);

`ifdef SNOOP_PERF_CNT_EN
      // The mid-burst reset clears both counters; only the last miss follows.
      check("hit cnt", snoop_hit_cnt, 32'd0);
      check("miss cnt", snoop_miss_cnt, 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
